uart_rom_loader: RTL

- UART boot loader for mother_board: receives a program image on uart_rx and writes it word by word into instruction ROM through a write port.
- Replaces direct hierarchical writes to rom.mem. The loader is the receiving end of the host's serial image stream.
- Sits between the board-level uart_rx pin and the ROM write port. The CPU is held off until done asserts.

---
 rtl/uart_rom_loader_if.sv | 14 +
 rtl/uart_rom_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rom_loader_if.sv
// ROM write port and loader status, driven by uart_rom_loader (master).
interface uart_rom_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              err;

  modport master (output wr_en, wr_addr, wr_data, busy, done, err);
  modport slave  (input  wr_en, wr_addr, wr_data, busy, done, err);
endinterface

// File: rtl/uart_rom_loader.sv
// UART boot loader: receives a length-prefixed little-endian word image on
// uart_rx (8N1, LSB first) and writes it into instruction ROM from address 0.
// Optional macro UART_ROM_LOADER_CHECKSUM_EN: a trailing XOR checksum byte
// over all payload bytes is required and verified before done.
module uart_rom_loader #(
  parameter int unsigned WAIT   = 868,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                uart_rx,
  uart_rom_loader_if.master   bus
);

  localparam int unsigned CNT_W  = $clog2(WAIT);
  localparam int unsigned HALF   = WAIT / 2;
  localparam int unsigned CAP    = 1 << ADDR_W;
  localparam int unsigned WCNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    LD_IDLE, LD_LEN_LO, LD_LEN_HI, LD_PAYLOAD, LD_DONE, LD_ERROR
`ifdef UART_ROM_LOADER_CHECKSUM_EN
    , LD_CHECK
`endif
  } ld_state_t;

`ifdef UART_ROM_LOADER_CHECKSUM_EN
  localparam ld_state_t LD_END = LD_CHECK;
`else
  localparam ld_state_t LD_END = LD_DONE;
`endif

  // ---------------- input synchronizer ----------------
  logic rx_s1, rx_s2, rx_s3;
  logic rx_fall_c;

  // two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall_c = rx_s3 & ~rx_s2;

  // ---------------- byte receiver ----------------
  rx_state_t        rx_state, rx_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift;
  logic             tick_half_c, tick_full_c;
  logic             start_ok_c, byte_valid_c, frame_err_c;

  assign tick_half_c = (bit_cnt == CNT_W'(HALF - 1));
  assign tick_full_c = (bit_cnt == CNT_W'(WAIT - 1));

  // receiver state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  // receiver next state: mid-bit sampling, glitch rejection in START
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall_c) rx_next = RX_START;
      RX_START: if (tick_half_c) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_full_c && (bit_idx == 3'd7)) rx_next = RX_STOP;
      RX_STOP:  if (tick_full_c) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // receiver event strobes
  always_comb begin
    start_ok_c   = 1'b0;
    byte_valid_c = 1'b0;
    frame_err_c  = 1'b0;
    if (rx_state == RX_START && tick_half_c && !rx_s2) start_ok_c = 1'b1;
    if (rx_state == RX_STOP && tick_full_c) begin
      byte_valid_c = rx_s2;
      frame_err_c  = ~rx_s2;
    end
  end

  // bit-period counter, bit index and LSB-first shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt  <= '0;
      bit_idx  <= '0;
      rx_shift <= 8'hFF;
    end else begin
      case (rx_state)
        RX_START: begin
          bit_idx <= '0;
          bit_cnt <= tick_half_c ? '0 : bit_cnt + CNT_W'(1);
        end
        RX_DATA: begin
          if (tick_full_c) begin
            bit_cnt  <= '0;
            bit_idx  <= bit_idx + 3'd1;
            rx_shift <= {rx_s2, rx_shift[7:1]};
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        RX_STOP: bit_cnt <= tick_full_c ? '0 : bit_cnt + CNT_W'(1);
        default: bit_cnt <= '0;
      endcase
    end
  end

  // ---------------- image loader ----------------
  ld_state_t         ld_state, ld_next;
  logic [7:0]        len_lo;
  logic [15:0]       len_c;
  logic [WCNT_W-1:0] len_q;
  logic [WCNT_W-1:0] word_cnt;
  logic [31:0]       asm_q, asm_next_c;
  logic [1:0]        byte_idx;
  logic              wr_en_q, busy_q, done_q, err_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              busy_d, done_d, err_d, wr_fire_c;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  assign len_c      = {rx_shift, len_lo};
  assign asm_next_c = {rx_shift, asm_q[31:8]};

  // loader state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ld_state <= LD_IDLE;
    else        ld_state <= ld_next;
  end

  // loader next state; DONE/ERROR are only left through reset
  always_comb begin
    ld_next = ld_state;
    case (ld_state)
      LD_IDLE:   if (start_ok_c) ld_next = LD_LEN_LO;
      LD_LEN_LO: begin
        if (frame_err_c)       ld_next = LD_ERROR;
        else if (byte_valid_c) ld_next = LD_LEN_HI;
      end
      LD_LEN_HI: begin
        if (frame_err_c) begin
          ld_next = LD_ERROR;
        end else if (byte_valid_c) begin
          if (len_c == 16'd0)          ld_next = LD_END;
          else if (32'(len_c) > CAP)   ld_next = LD_ERROR;
          else                         ld_next = LD_PAYLOAD;
        end
      end
      LD_PAYLOAD: begin
        if (frame_err_c)                       ld_next = LD_ERROR;
        else if (wr_en_q && (word_cnt == len_q)) ld_next = LD_END;
      end
`ifdef UART_ROM_LOADER_CHECKSUM_EN
      LD_CHECK: begin
        if (frame_err_c)       ld_next = LD_ERROR;
        else if (byte_valid_c) ld_next = (rx_shift == csum_q) ? LD_DONE : LD_ERROR;
      end
`endif
      LD_DONE:   ld_next = LD_DONE;
      LD_ERROR:  ld_next = LD_ERROR;
      default:   ld_next = LD_ERROR;
    endcase
  end

  // loader outputs, decoded from the next state so they register with it
  always_comb begin
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    wr_fire_c = 1'b0;
    case (ld_next)
      LD_LEN_LO, LD_LEN_HI, LD_PAYLOAD: busy_d = 1'b1;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
      LD_CHECK:                         busy_d = 1'b1;
`endif
      LD_DONE:                          done_d = 1'b1;
      LD_ERROR:                         err_d  = 1'b1;
      default:                          ;
    endcase
    wr_fire_c = (ld_state == LD_PAYLOAD) && byte_valid_c && (byte_idx == 2'd3);
  end

  // length capture, word assembly, write port and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_lo    <= '0;
      len_q     <= '0;
      word_cnt  <= '0;
      asm_q     <= '0;
      byte_idx  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wr_en_q <= wr_fire_c;
      if (ld_state == LD_LEN_LO && byte_valid_c) len_lo <= rx_shift;
      if (ld_state == LD_LEN_HI && byte_valid_c) len_q  <= WCNT_W'(len_c);
      if (ld_state == LD_PAYLOAD && byte_valid_c) begin
        asm_q    <= asm_next_c;
        byte_idx <= byte_idx + 2'd1;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
        csum_q   <= csum_q ^ rx_shift;
`endif
      end
      if (wr_fire_c) begin
        wr_addr_q <= ADDR_W'(word_cnt);
        wr_data_q <= asm_next_c;
        word_cnt  <= word_cnt + WCNT_W'(1);
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule
